// File: rtl/glitch_pulse_gen.sv
// Glitch pulse generator: waits for a qualified trigger edge after arming, then
// emits one pulse of programmed width after a programmed delay.
module glitch_pulse_gen #(
  parameter int DELAY_BITS = 32,
  parameter int WIDTH_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic                  disarm_i,
  input  logic [DELAY_BITS-1:0] delay_i,
  input  logic [WIDTH_BITS-1:0] width_i,
  input  logic                  polarity_i,
  input  logic                  trigger_i,
  output logic                  pulse_o,
  output logic                  armed_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // One-hot encoding so status outputs come straight off single state flops.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ARMED = 4'b0010,
    ST_DELAY = 4'b0100,
    ST_PULSE = 4'b1000
  } state_t;

  localparam int IDX_IDLE  = 0;
  localparam int IDX_ARMED = 1;
  localparam int IDX_PULSE = 3;

  state_t                  state_q, state_d;
  logic [DELAY_BITS-1:0]   cnt_q, cnt_d;
  logic [DELAY_BITS-1:0]   delay_q, delay_d;
  logic [WIDTH_BITS-1:0]   width_q, width_d;
  logic                    pol_q, pol_d;
  logic                    done_q, done_d;
  logic                    sync_s1_q, sync_s2_q, sync_s3_q;
  logic                    rise_edge, fall_edge, trig_edge;

  // Counter reload for the pulse phase; counts W-1 down to 0 for W cycles.
  function automatic logic [DELAY_BITS-1:0] width_load(input logic [WIDTH_BITS-1:0] w);
    return DELAY_BITS'(w) - DELAY_BITS'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1_q <= 1'b0;
      sync_s2_q <= 1'b0;
      sync_s3_q <= 1'b0;
    end else begin
      sync_s1_q <= trigger_i;
      sync_s2_q <= sync_s1_q;
      sync_s3_q <= sync_s2_q;
    end
  end

  assign rise_edge = sync_s2_q & ~sync_s3_q;
  assign fall_edge = ~sync_s2_q & sync_s3_q;
  assign trig_edge = pol_q ? fall_edge : rise_edge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    width_d = width_q;
    pol_d   = pol_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d = ST_ARMED;
          delay_d = delay_i;
          pol_d   = polarity_i;
          width_d = (width_i == '0) ? WIDTH_BITS'(1) : width_i;
        end
      end
      ST_ARMED: begin
        if (disarm_i) begin
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          if (delay_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = width_load(width_q);
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_q - DELAY_BITS'(1);
          end
        end
      end
      ST_DELAY: begin
        if (disarm_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = width_load(width_q);
        end else begin
          cnt_d = cnt_q - DELAY_BITS'(1);
        end
      end
      ST_PULSE: begin
        // Disarm is deliberately not looked at here: a started pulse always completes.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - DELAY_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      width_q <= '0;
      pol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      width_q <= width_d;
      pol_q   <= pol_d;
      done_q  <= done_d;
    end
  end

  assign pulse_o = state_q[IDX_PULSE];
  assign armed_o = state_q[IDX_ARMED];
  assign busy_o  = ~state_q[IDX_IDLE];
  assign done_o  = done_q;

endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Cycle-accurate glitch pulse generator, downstream of `glitch_control`. It latches a delay and width on arm, then waits for a qualified edge on the external trigger. After the programmed delay it drives a single pulse of the programmed width. The pulse output feeds the glitch switch driver. Armed, busy and done status return to `glitch_control` for UART reporting.

## Interface

Parameters:
- `DELAY_BITS`, default 32: width of the delay counter and `delay_i`.
- `WIDTH_BITS`, default 16: width of the pulse-length counter and `width_i`.

Ports:
- `clk`, input, 1: single system clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `arm_i`, input, 1: one-cycle request to arm. Honoured only in IDLE.
- `disarm_i`, input, 1: abort request. Honoured in ARMED and DELAY.
- `delay_i`, input, DELAY_BITS: number of cycles between the detected trigger edge and pulse start. Sampled on arm.
- `width_i`, input, WIDTH_BITS: pulse length in cycles. Sampled on arm.
- `polarity_i`, input, 1: trigger edge select, 0 = rising, 1 = falling. Sampled on arm.
- `trigger_i`, input, 1: asynchronous target trigger.
- `pulse_o`, output, 1: glitch pulse, active high, driven directly from a flop.
- `armed_o`, output, 1: high while in ARMED.
- `busy_o`, output, 1: high in any state other than IDLE.
- `done_o`, output, 1: one-cycle strobe when a pulse completes.

## Operation

Trigger path:
- `trigger_i` passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
- Rising edge = s2 & ~s3. Falling edge = ~s2 & s3.
- Only the edge selected by the latched polarity is used. A static level never triggers.

States: IDLE, ARMED, DELAY, PULSE. A single down-counter `cnt` is shared, DELAY_BITS wide; width values are zero-extended.

- IDLE:
  - `arm_i` → ARMED. Latch `delay_i`, `polarity_i` and `width_i`.
  - If `width_i`==0, the latched width is forced to 1.
- ARMED:
  - `disarm_i` → IDLE.
  - Else, on a qualified edge: if delay==0 → PULSE with `cnt`=width−1; otherwise → DELAY with `cnt`=delay−1.
- DELAY:
  - `disarm_i` → IDLE with no pulse.
  - Else, if `cnt`==0 → PULSE with `cnt`=width−1.
  - Else `cnt`−1.
- PULSE:
  - `pulse_o`=1.
  - If `cnt`==0 → IDLE and assert `done_o` for one cycle. Else `cnt`−1.
  - `disarm_i` is ignored, so pulses are never truncated (no runt glitches).

Boundary rules:
- `arm_i` outside IDLE: ignored. Latched values are unchanged.
- `arm_i` and an edge in the same IDLE cycle: the edge is ignored. Only edges seen while in ARMED count.
- Trigger already at the active level when arming: a fresh edge is required.
- `disarm_i` together with a qualified edge in ARMED: disarm wins → IDLE.
- `disarm_i` in the same cycle `cnt` reaches 0 in DELAY: disarm wins, no pulse.
- Further trigger edges during DELAY or PULSE: ignored (one pulse per arm).
- Maximum delay: 2^DELAY_BITS−1. Maximum width: 2^WIDTH_BITS−1. The counter does not wrap.

Reset:
- Asynchronous assertion from any state, including mid-pulse.
- `pulse_o`=0, `armed_o`=0, `busy_o`=0, `done_o`=0, state=IDLE, `cnt`=0, s1/s2/s3=0, all latched configuration = 0.
- The synchronizer flops reset to 0. With a rising trigger selected, a trigger already high at reset release therefore yields one edge, which is ignored unless the block is already ARMED.

## Timing

- Let edge T be the first clock edge at which s1 samples the new active trigger level. The qualified edge is valid in the cycle after T+1.
- FSM leaves ARMED at edge T+2. `armed_o` falls at the same edge.
- `pulse_o` rises at edge T+2+D, where D = latched delay. With D=0, it rises at T+2.
- `pulse_o` stays high exactly W cycles and falls at edge T+2+D+W. `done_o` is high for the cycle following that edge.
- `busy_o` falls at edge T+2+D+W.
- `arm_i` at edge A: `armed_o` and `busy_o` are high after edge A.
- Re-arming is possible in the cycle `done_o` is high, since the state is then IDLE.
- `armed_o`, `busy_o` and `pulse_o` are registered or decoded from one-hot state flops. No combinational path from any input to any output.

## Test plan

- **Reset values:** assert `rst` mid-PULSE with delay=5, width=10 → `pulse_o` drops immediately (asynchronous) and all outputs read 0.
- **Basic pulse:** arm with delay=4, width=3, polarity=0, then raise `trigger_i` at edge T → `pulse_o` high at edges T+6..T+8, low at T+9; `done_o` is a single cycle after T+9.
- **Zero cases:** delay=0, width=0 → 1-cycle pulse rising at T+2. Falling-edge polarity=1 with `trigger_i` dropping → same timing referenced to the fall.
- **Abort:** arm with delay=100, edge, then `disarm_i` at T+50 → no pulse, no `done_o`, `busy_o`=0 at T+51. `disarm_i` at T+2+100+1 (in PULSE) → full-width pulse.
- **Edge qualification:** hold `trigger_i` high while arming → no pulse until a low→high transition. A second edge during DELAY → exactly one pulse.
- **Arm hygiene:** `arm_i` pulsed during DELAY with new delay=1 → original timing kept. Back-to-back re-arm in the `done_o` cycle → second pulse timed correctly.
